// File: rtl/attack_gen.sv
// Attack-set generator: walks the move pattern of the piece on a source square,
// one candidate square per clock, and reports the attacked squares as a 64-bit map.
module attack_gen #(
  parameter int PIECE_WIDTH = 4,
  parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
  parameter int BOARD_WIDTH = SIDE_WIDTH * 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BOARD_WIDTH-1:0] board,
  input  logic                   board_valid,
  input  logic [2:0]             src_row,
  input  logic [2:0]             src_col,
  output logic                   busy,
  output logic [63:0]            attacks,
  output logic                   attacks_valid
);

  // Piece codes: low three bits select the piece type, bit 3 marks black.
  localparam logic [PIECE_WIDTH-1:0] P_EMPTY  = PIECE_WIDTH'(0);
  localparam logic [PIECE_WIDTH-1:0] P_PAWN   = PIECE_WIDTH'(1);
  localparam logic [PIECE_WIDTH-1:0] P_KNIGHT = PIECE_WIDTH'(2);
  localparam logic [PIECE_WIDTH-1:0] P_BISHOP = PIECE_WIDTH'(3);
  localparam logic [PIECE_WIDTH-1:0] P_ROOK   = PIECE_WIDTH'(4);
  localparam logic [PIECE_WIDTH-1:0] P_QUEEN  = PIECE_WIDTH'(5);
  localparam logic [PIECE_WIDTH-1:0] P_KING   = PIECE_WIDTH'(6);
  localparam logic [PIECE_WIDTH-1:0] P_BLACK  = PIECE_WIDTH'(8);

  // state | meaning
  // IDLE  | waiting for a request
  // SCAN  | one candidate square per cycle; finishes when no candidate remains
  // DONE  | result pulse; a new request may be accepted here
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [2:0] {M_SLIDE, M_KING, M_KNIGHT, M_PAWN_W, M_PAWN_B} mode_t;

  state_t                 r_state;
  state_t                 w_next_state;
  mode_t                  r_mode;
  mode_t                  w_dec_mode;
  logic [BOARD_WIDTH-1:0] r_board;
  logic [2:0]             r_src_row;
  logic [2:0]             r_src_col;
  logic [7:0]             r_pending;
  logic [3:0]             r_dist;
  logic [63:0]            r_acc;

  logic [PIECE_WIDTH-1:0] w_in_sq [64];
  logic [PIECE_WIDTH-1:0] w_sq    [64];
  logic [PIECE_WIDTH-1:0] w_src_code;
  logic [7:0]             w_dec_mask;
  logic                   w_accept;
  logic [2:0]             w_cur_idx;
  logic [7:0]             w_cur_bit;
  logic signed [5:0]      w_dr;
  logic signed [5:0]      w_dc;
  logic signed [5:0]      w_dist_s;
  logic signed [5:0]      w_step_r;
  logic signed [5:0]      w_step_c;
  logic signed [5:0]      w_cand_r;
  logic signed [5:0]      w_cand_c;
  logic                   w_on_board;
  logic [5:0]             w_cand_idx;
  logic                   w_continue;

  for (genvar g = 0; g < 64; g++) begin : g_sq
    assign w_in_sq[g] = board[(g / 8) * SIDE_WIDTH + (g % 8) * PIECE_WIDTH +: PIECE_WIDTH];
    assign w_sq[g]    = r_board[(g / 8) * SIDE_WIDTH + (g % 8) * PIECE_WIDTH +: PIECE_WIDTH];
  end

  assign w_src_code = w_in_sq[{src_row, src_col}];
  assign w_accept   = board_valid && (r_state != SCAN);
  assign busy       = (r_state == SCAN);

  // Pending mask bit k = direction/offset k still to be walked; unused ones are never set.
  always_comb begin
    w_dec_mode = M_SLIDE;
    w_dec_mask = 8'h00;
    case (w_src_code)
      P_ROOK,   P_ROOK   | P_BLACK: begin w_dec_mode = M_SLIDE;  w_dec_mask = 8'h55; end
      P_BISHOP, P_BISHOP | P_BLACK: begin w_dec_mode = M_SLIDE;  w_dec_mask = 8'hAA; end
      P_QUEEN,  P_QUEEN  | P_BLACK: begin w_dec_mode = M_SLIDE;  w_dec_mask = 8'hFF; end
      P_KING,   P_KING   | P_BLACK: begin w_dec_mode = M_KING;   w_dec_mask = 8'hFF; end
      P_KNIGHT, P_KNIGHT | P_BLACK: begin w_dec_mode = M_KNIGHT; w_dec_mask = 8'hFF; end
      P_PAWN:                       begin w_dec_mode = M_PAWN_W; w_dec_mask = 8'h03; end
      P_PAWN | P_BLACK:             begin w_dec_mode = M_PAWN_B; w_dec_mask = 8'h03; end
      default: ;
    endcase
  end

  always_comb begin
    w_cur_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) w_cur_idx = 3'(i);
    end
  end
  assign w_cur_bit = 8'b1 << w_cur_idx;

  always_comb begin
    w_dr = 6'sd0;
    w_dc = 6'sd0;
    case (r_mode)
      M_KNIGHT: begin
        case (w_cur_idx)
          3'd0: begin w_dr =  6'sd2; w_dc =  6'sd1; end
          3'd1: begin w_dr =  6'sd1; w_dc =  6'sd2; end
          3'd2: begin w_dr = -6'sd1; w_dc =  6'sd2; end
          3'd3: begin w_dr = -6'sd2; w_dc =  6'sd1; end
          3'd4: begin w_dr = -6'sd2; w_dc = -6'sd1; end
          3'd5: begin w_dr = -6'sd1; w_dc = -6'sd2; end
          3'd6: begin w_dr =  6'sd1; w_dc = -6'sd2; end
          default: begin w_dr = 6'sd2; w_dc = -6'sd1; end
        endcase
      end
      M_PAWN_W: begin w_dr =  6'sd1; w_dc = w_cur_idx[0] ? 6'sd1 : -6'sd1; end
      M_PAWN_B: begin w_dr = -6'sd1; w_dc = w_cur_idx[0] ? 6'sd1 : -6'sd1; end
      default: begin
        case (w_cur_idx)
          3'd0: begin w_dr =  6'sd1; w_dc =  6'sd0; end
          3'd1: begin w_dr =  6'sd1; w_dc =  6'sd1; end
          3'd2: begin w_dr =  6'sd0; w_dc =  6'sd1; end
          3'd3: begin w_dr = -6'sd1; w_dc =  6'sd1; end
          3'd4: begin w_dr = -6'sd1; w_dc =  6'sd0; end
          3'd5: begin w_dr = -6'sd1; w_dc = -6'sd1; end
          3'd6: begin w_dr =  6'sd0; w_dc = -6'sd1; end
          default: begin w_dr = 6'sd1; w_dc = -6'sd1; end
        endcase
      end
    endcase
  end

  // Unit steps scale with ray distance; non-sliding patterns keep distance at 1.
  assign w_dist_s   = signed'({2'b00, r_dist});
  assign w_step_r   = (w_dr == 6'sd1) ? w_dist_s : (w_dr == -6'sd1) ? -w_dist_s : w_dr;
  assign w_step_c   = (w_dc == 6'sd1) ? w_dist_s : (w_dc == -6'sd1) ? -w_dist_s : w_dc;
  assign w_cand_r   = signed'({3'b000, r_src_row}) + w_step_r;
  assign w_cand_c   = signed'({3'b000, r_src_col}) + w_step_c;
  assign w_on_board = (w_cand_r[5:3] == 3'b000) && (w_cand_c[5:3] == 3'b000);
  assign w_cand_idx = {w_cand_r[2:0], w_cand_c[2:0]};
  assign w_continue = (r_mode == M_SLIDE) && w_on_board && (w_sq[w_cand_idx] == P_EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SCAN;
      SCAN:    if (r_pending == 8'h00) w_next_state = DONE;
      DONE:    w_next_state = w_accept ? SCAN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_board       <= '0;
      r_src_row     <= 3'd0;
      r_src_col     <= 3'd0;
      r_mode        <= M_SLIDE;
      r_pending     <= 8'h00;
      r_dist        <= 4'd1;
      r_acc         <= 64'h0;
      attacks       <= 64'h0;
      attacks_valid <= 1'b0;
    end else begin
      attacks_valid <= 1'b0;
      if (w_accept) begin
        r_board   <= board;
        r_src_row <= src_row;
        r_src_col <= src_col;
        r_mode    <= w_dec_mode;
        r_pending <= w_dec_mask;
        r_dist    <= 4'd1;
        r_acc     <= 64'h0;
      end else if (r_state == SCAN) begin
        if (r_pending == 8'h00) begin
          attacks       <= r_acc;
          attacks_valid <= 1'b1;
        end else begin
          if (w_on_board) r_acc[w_cand_idx] <= 1'b1;
          if (w_continue) begin
            r_dist <= r_dist + 4'd1;
          end else begin
            r_pending <= r_pending & ~w_cur_bit;
            r_dist    <= 4'd1;
          end
        end
      end
    end
  end

endmodule
